// File: rtl/pc_ir_datapath.sv
// ---------------------------------------------------------------------------
// pc_ir_datapath
//   Register datapath for a multicycle MIPS-style core: program counter,
//   instruction register, memory data register, ALU output register and the
//   two register-file operand latches, plus the memory address/write-data
//   muxing and the instruction field decode.
//
// Ports
//   Clk_i           clock, all state updates on the rising edge
//   Reset_i         synchronous active-high reset, clears every register
//   PCWrite_i       unconditional PC write enable
//   isBranch_i      conditional PC write enable, qualified by Zero_i
//   IRWrite_i       instruction register load enable
//   lorD_i          memory address select (0: PC, 1: ALUOut)
//   PCSource_i      next-PC select (00 ALUResult, 01 ALUOut, 10 jump, 11 hold)
//   Zero_i          ALU zero flag
//   ALUResult_i     combinational ALU result
//   MemRdata_i      memory read data
//   RegA_in_i       register-file read port A
//   RegB_in_i       register-file read port B
//   PC_o            program counter
//   MemAddr_o       memory address
//   MemWdata_o      memory write data (the B latch)
//   IR_o            instruction register
//   Op_o, funct_o, rs_o, rt_o, rd_o, imm_o   instruction fields of IR_o
//   MDR_o, ALUOut_o, A_o, B_o                datapath registers
// ---------------------------------------------------------------------------
module pc_ir_datapath (
   input  logic        Clk_i,
   input  logic        Reset_i,
   input  logic        PCWrite_i,
   input  logic        isBranch_i,
   input  logic        IRWrite_i,
   input  logic        lorD_i,
   input  logic [1:0]  PCSource_i,
   input  logic        Zero_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] MemRdata_i,
   input  logic [31:0] RegA_in_i,
   input  logic [31:0] RegB_in_i,
   output logic [31:0] PC_o,
   output logic [31:0] MemAddr_o,
   output logic [31:0] MemWdata_o,
   output logic [31:0] IR_o,
   output logic [5:0]  Op_o,
   output logic [5:0]  funct_o,
   output logic [4:0]  rs_o,
   output logic [4:0]  rt_o,
   output logic [4:0]  rd_o,
   output logic [15:0] imm_o,
   output logic [31:0] MDR_o,
   output logic [31:0] ALUOut_o,
   output logic [31:0] A_o,
   output logic [31:0] B_o
);

   logic [31:0] pc_q,      pc_d;
   logic [31:0] ir_q,      ir_d;
   logic [31:0] mdr_q;
   logic [31:0] alu_out_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        pc_en;

   // A branch only writes the PC when the ALU reports equality; PCWrite
   // overrides that qualification.
   assign pc_en = PCWrite_i | (isBranch_i & Zero_i);

   always_comb begin
      pc_d = pc_q;
      if (pc_en) begin
         case (PCSource_i)
            2'b00:   pc_d = ALUResult_i;
            2'b01:   pc_d = alu_out_q;
            // Jump target keeps the current PC's 256 MB region.
            2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_d = pc_q;   // reserved encoding: hold
         endcase
      end
   end

   always_comb begin
      ir_d = ir_q;
      if (IRWrite_i) begin
         ir_d = MemRdata_i;
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         pc_q      <= 32'h0000_0000;
         ir_q      <= 32'h0000_0000;
         mdr_q     <= 32'h0000_0000;
         alu_out_q <= 32'h0000_0000;
         a_q       <= 32'h0000_0000;
         b_q       <= 32'h0000_0000;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         // These latches are free-running: they capture every cycle so the
         // next control step always sees the previous step's values.
         mdr_q     <= MemRdata_i;
         alu_out_q <= ALUResult_i;
         a_q       <= RegA_in_i;
         b_q       <= RegB_in_i;
      end
   end

   assign MemAddr_o  = lorD_i ? alu_out_q : pc_q;
   assign MemWdata_o = b_q;

   assign PC_o     = pc_q;
   assign IR_o     = ir_q;
   assign MDR_o    = mdr_q;
   assign ALUOut_o = alu_out_q;
   assign A_o      = a_q;
   assign B_o      = b_q;

   // Fields are decoded from the registered instruction, never from the
   // memory bus, so they stay stable while memory is reused for data.
   assign Op_o    = ir_q[31:26];
   assign rs_o    = ir_q[25:21];
   assign rt_o    = ir_q[20:16];
   assign rd_o    = ir_q[15:11];
   assign imm_o   = ir_q[15:0];
   assign funct_o = ir_q[5:0];

endmodule

// File: tb/tb_pc_ir_datapath.sv
// ---------------------------------------------------------------------------
// tb_pc_ir_datapath
//   Directed self-checking bench for pc_ir_datapath. Each task drives one
//   scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_ir_datapath;

   logic        clk;
   logic        reset;
   logic        pc_write;
   logic        is_branch;
   logic        ir_write;
   logic        lord;
   logic [1:0]  pc_source;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] mem_rdata;
   logic [31:0] reg_a_in;
   logic [31:0] reg_b_in;
   logic [31:0] pc;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] ir;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] mdr;
   logic [31:0] alu_out;
   logic [31:0] a;
   logic [31:0] b;

   int checks = 0;
   int errors = 0;

   pc_ir_datapath dut (
      .Clk_i       (clk),
      .Reset_i     (reset),
      .PCWrite_i   (pc_write),
      .isBranch_i  (is_branch),
      .IRWrite_i   (ir_write),
      .lorD_i      (lord),
      .PCSource_i  (pc_source),
      .Zero_i      (zero),
      .ALUResult_i (alu_result),
      .MemRdata_i  (mem_rdata),
      .RegA_in_i   (reg_a_in),
      .RegB_in_i   (reg_b_in),
      .PC_o        (pc),
      .MemAddr_o   (mem_addr),
      .MemWdata_o  (mem_wdata),
      .IR_o        (ir),
      .Op_o        (op),
      .funct_o     (funct),
      .rs_o        (rs),
      .rt_o        (rt),
      .rd_o        (rd),
      .imm_o       (imm),
      .MDR_o       (mdr),
      .ALUOut_o    (alu_out),
      .A_o         (a),
      .B_o         (b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset     = 1'b0;
      pc_write  = 1'b0;
      is_branch = 1'b0;
      ir_write  = 1'b0;
      lord      = 1'b0;
      pc_source = 2'b00;
      zero      = 1'b0;
   endtask

   task automatic test_reset();
      // Every enable asserted with non-zero data: reset must still win.
      reset = 1'b1; pc_write = 1'b1; is_branch = 1'b1; ir_write = 1'b1;
      lord = 1'b0; pc_source = 2'b00; zero = 1'b1;
      alu_result = 32'hAAAA_5555; mem_rdata = 32'h1234_5678;
      reg_a_in = 32'hCAFE_0001; reg_b_in = 32'hCAFE_0002;
      tick();
      checks++; if (pc      !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      checks++; if (ir      !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want %h", ir, 32'h0); end
      checks++; if (mdr     !== 32'h0) begin errors++; $display("FAIL reset_mdr got %h want %h", mdr, 32'h0); end
      checks++; if (alu_out !== 32'h0) begin errors++; $display("FAIL reset_aluout got %h want %h", alu_out, 32'h0); end
      checks++; if (a       !== 32'h0) begin errors++; $display("FAIL reset_a got %h want %h", a, 32'h0); end
      checks++; if (b       !== 32'h0) begin errors++; $display("FAIL reset_b got %h want %h", b, 32'h0); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_memaddr got %h want %h", mem_addr, 32'h0); end
      $display("reset: pc=%h ir=%h mdr=%h aluout=%h", pc, ir, mdr, alu_out);
   endtask

   task automatic test_fetch();
      idle_inputs();
      mem_rdata = 32'h8C43_0004; ir_write = 1'b1; pc_write = 1'b1;
      pc_source = 2'b00; alu_result = 32'h0000_0004;
      reg_a_in = 32'h0000_0011; reg_b_in = 32'h0000_0022;
      tick();
      checks++; if (ir    !== 32'h8C43_0004) begin errors++; $display("FAIL fetch_ir got %h want %h", ir, 32'h8C43_0004); end
      checks++; if (op    !== 6'b100011) begin errors++; $display("FAIL fetch_op got %b want %b", op, 6'b100011); end
      checks++; if (rs    !== 5'd2) begin errors++; $display("FAIL fetch_rs got %0d want %0d", rs, 2); end
      checks++; if (rt    !== 5'd3) begin errors++; $display("FAIL fetch_rt got %0d want %0d", rt, 3); end
      checks++; if (rd    !== 5'd0) begin errors++; $display("FAIL fetch_rd got %0d want %0d", rd, 0); end
      checks++; if (imm   !== 16'h0004) begin errors++; $display("FAIL fetch_imm got %h want %h", imm, 16'h0004); end
      checks++; if (funct !== 6'd4) begin errors++; $display("FAIL fetch_funct got %0d want %0d", funct, 4); end
      checks++; if (pc    !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, 32'h4); end
      checks++; if (mdr   !== 32'h8C43_0004) begin errors++; $display("FAIL fetch_mdr got %h want %h", mdr, 32'h8C43_0004); end
      checks++; if (a !== 32'h11 || b !== 32'h22) begin errors++; $display("FAIL fetch_ab got %h/%h want %h/%h", a, b, 32'h11, 32'h22); end
      $display("fetch: ir=%h pc=%h op=%b rs=%0d rt=%0d imm=%h", ir, pc, op, rs, rt, imm);
      // Fields must follow IR, not the memory bus.
      ir_write = 1'b0; pc_write = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (op !== 6'b100011 || imm !== 16'h0004) begin errors++; $display("FAIL field_source got op=%b imm=%h want op=%b imm=%h", op, imm, 6'b100011, 16'h0004); end
   endtask

   task automatic test_branch();
      idle_inputs();
      alu_result = 32'h0000_0040;
      tick();
      checks++; if (alu_out !== 32'h40) begin errors++; $display("FAIL branch_aluout got %h want %h", alu_out, 32'h40); end
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL branch_idle_pc got %h want %h", pc, 32'h4); end
      // Taken: PC takes the registered ALUOut, not the live ALUResult.
      is_branch = 1'b1; zero = 1'b1; pc_source = 2'b01; alu_result = 32'h0000_0099;
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_taken_pc got %h want %h", pc, 32'h40); end
      $display("branch taken: pc=%h", pc);
      zero = 1'b0; alu_result = 32'h0000_0080;
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_not_taken_pc got %h want %h", pc, 32'h40); end
      $display("branch not taken: pc=%h", pc);
   endtask

   task automatic test_jump();
      idle_inputs();
      pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h1000_0008;
      ir_write = 1'b1; mem_rdata = 32'h0800_0010;
      tick();
      checks++; if (pc !== 32'h1000_0008 || ir !== 32'h0800_0010) begin errors++; $display("FAIL jump_setup got pc=%h ir=%h want pc=%h ir=%h", pc, ir, 32'h1000_0008, 32'h0800_0010); end
      ir_write = 1'b0; pc_source = 2'b10; alu_result = 32'h0000_0000;
      tick();
      checks++; if (pc !== 32'h1000_0040) begin errors++; $display("FAIL jump_pc got %h want %h", pc, 32'h1000_0040); end
      $display("jump: pc=%h", pc);
   endtask

   task automatic test_load_path();
      idle_inputs();
      alu_result = 32'h0000_0100; reg_a_in = 32'h0BAD_F00D; reg_b_in = 32'h1234_5678;
      tick();
      lord = 1'b1;
      #1;
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL load_memaddr got %h want %h", mem_addr, 32'h100); end
      checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL load_memwdata got %h want %h", mem_wdata, 32'h1234_5678); end
      checks++; if (a !== 32'h0BAD_F00D) begin errors++; $display("FAIL load_a got %h want %h", a, 32'h0BAD_F00D); end
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (mdr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_mdr got %h want %h", mdr, 32'hDEAD_BEEF); end
      checks++; if (ir !== 32'h0800_0010) begin errors++; $display("FAIL load_ir_hold got %h want %h", ir, 32'h0800_0010); end
      lord = 1'b0;
      #1;
      checks++; if (mem_addr !== 32'h1000_0040) begin errors++; $display("FAIL load_memaddr_pc got %h want %h", mem_addr, 32'h1000_0040); end
      $display("load path: mdr=%h ir=%h memaddr=%h", mdr, ir, mem_addr);
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h0000_0001; vals[1] = 32'h8000_0000; vals[2] = 32'h5A5A_A5A5;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         mem_rdata = vals[i]; alu_result = ~vals[i];
         tick();
         checks++; if (mdr !== vals[i] || alu_out !== ~vals[i]) begin errors++; $display("FAIL b2b_%0d got mdr=%h aluout=%h want mdr=%h aluout=%h", i, mdr, alu_out, vals[i], ~vals[i]); end
         $display("b2b %0d: mdr=%h aluout=%h", i, mdr, alu_out);
      end
   endtask

   task automatic test_reserved_wrap();
      idle_inputs();
      pc_write = 1'b1; pc_source = 2'b11; alu_result = 32'h0000_1234;
      tick();
      checks++; if (pc !== 32'h1000_0040) begin errors++; $display("FAIL reserved_hold_pc got %h want %h", pc, 32'h1000_0040); end
      pc_source = 2'b00; alu_result = 32'hFFFF_FFFC;
      tick();
      alu_result = 32'h0000_0000;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
      // PCWrite dominates an untaken branch condition.
      is_branch = 1'b1; zero = 1'b0; alu_result = 32'h0000_0024;
      tick();
      checks++; if (pc !== 32'h24) begin errors++; $display("FAIL pcwrite_dominates_pc got %h want %h", pc, 32'h24); end
      $display("reserved/wrap: pc=%h", pc);
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      reset = 1'b1; pc_write = 1'b1; ir_write = 1'b1; is_branch = 1'b1; zero = 1'b1;
      mem_rdata = 32'h1111_2222; alu_result = 32'h3333_4444;
      reg_a_in = 32'h5555_6666; reg_b_in = 32'h7777_8888;
      checks++; if (pc !== 32'h24 || ir === 32'h0) begin errors++; $display("FAIL midreset_setup got pc=%h ir=%h want pc=%h ir nonzero", pc, ir, 32'h24); end
      tick();
      checks++; if ({pc, ir, mdr, alu_out, a, b} !== 192'h0) begin errors++; $display("FAIL midreset_regs got pc=%h ir=%h mdr=%h aluout=%h a=%h b=%h want all 0", pc, ir, mdr, alu_out, a, b); end
      idle_inputs();
      #1;
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL midreset_memaddr got %h want %h", mem_addr, 32'h0); end
      pc_write = 1'b1; alu_result = 32'h0000_0004;
      tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc got %h want %h", pc, 32'h4); end
      $display("mid reset: pc=%h ir=%h", pc, ir);
   endtask

   initial begin
      idle_inputs();
      alu_result = 32'h0; mem_rdata = 32'h0; reg_a_in = 32'h0; reg_b_in = 32'h0;
      test_reset();
      test_fetch();
      test_branch();
      test_jump();
      test_load_path();
      test_back_to_back();
      test_reserved_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
